// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises a data port and a fetch port onto one memory controller.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int READ_WAIT  = 2,
  parameter int WR_PULSE   = 2,
  parameter int WR_TIMEOUT = 15
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        mem_is_write,
  output logic        mem_opt_is_lw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy,
  output logic        wr_timeout
);
  localparam logic [2:0] S_IDLE = 3'd0, S_RD = 3'd1, S_WRP = 3'd2, S_WRW = 3'd3, S_RESP = 3'd4;
  localparam logic [3:0] RW_END = 4'(READ_WAIT - 1);
  localparam logic [3:0] WP_END = 4'(WR_PULSE - 1);
  localparam logic [3:0] TO_END = 4'(WR_TIMEOUT - 1);
  logic [2:0] state;
  logic [3:0] cnt;
  logic       port;
  logic       pick_i;
`ifdef MEM_ARB_RR_EN
  logic ptr;
  always_comb pick_i = i_req && (!d_req || ptr);
  always_ff @(posedge clk50M)
    if (rst) ptr <= 1'b0;
    else if (state == S_IDLE && (d_req || i_req)) ptr <= !pick_i;
`else
  always_comb pick_i = i_req && !d_req;
`endif
  assign mem_is_write  = state == S_WRP;
  assign mem_opt_is_lw = state == S_RD;
  assign d_ack         = state == S_RESP && !port;
  assign i_ack         = state == S_RESP && port;
  always_ff @(posedge clk50M)
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      port        <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      d_rdata     <= '0;
      i_rdata     <= '0;
      wr_timeout  <= 1'b0;
    end else begin
      cnt <= cnt + 4'd1;
      case (state)
        S_IDLE: if (d_req || i_req) begin
          port     <= pick_i;
          cnt      <= '0;
          mem_addr <= (pick_i ? i_addr : d_addr) & ~32'd3;
          if (!pick_i) mem_data_in <= d_wdata;
          state    <= (!pick_i && d_we) ? S_WRP : S_RD;
        end
        S_RD: if (cnt == RW_END) begin
          if (port) i_rdata <= mem_data_out;
          else d_rdata <= mem_data_out;
          state <= S_RESP;
        end
        S_WRP: if (cnt == WP_END) begin
          cnt   <= '0;
          state <= S_WRW;
        end
        // busy still high on the last allowed cycle means the controller never finished
        S_WRW: if (!mem_busy || cnt == TO_END) begin
          wr_timeout <= wr_timeout | mem_busy;
          state      <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and randomized pairs against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int RW = 2, WP = 2, TO = 15;
  logic clk50M = 0, rst = 1;
  logic d_req = 0, d_we = 0, i_req = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, i_addr = 0;
  logic [31:0] d_rdata, i_rdata, mem_addr, mem_data_in;
  logic d_ack, i_ack, mem_is_write, mem_opt_is_lw, wr_timeout;
  logic [31:0] mem_data_out = 0;
  logic mem_busy = 0;
  int checks = 0, errors = 0;
  int busy_len = 0, bcnt = 0;
  logic busy_stuck = 0, cwe_q = 0;
  logic prev_we = 0, seen_pulse = 0;
  int low_run = 0;
  logic rr_i = 0;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] shadow [logic [29:0]];
  typedef struct {
    logic dv, dwe, stuck, iv, to;
    logic [31:0] daddr, dwdata, iaddr, d_rd, i_rd, maddr;
    int blen, d_at, i_at;
  } vec_t;
  vec_t tbl [8];

  mem_port_arbiter #(.READ_WAIT(RW), .WR_PULSE(WP), .WR_TIMEOUT(TO)) dut (
    .clk50M(clk50M), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .mem_is_write(mem_is_write), .mem_opt_is_lw(mem_opt_is_lw), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_busy(mem_busy), .wr_timeout(wr_timeout)
  );

  initial forever #10 clk50M = ~clk50M;

  // controller model: samples is_write on the falling edge, stores on its rising edge, then stays busy
  initial begin
    mem[30'h04000001] = 32'h3C1D8000;
    forever begin
      @(negedge clk50M);
      if (mem_is_write && !cwe_q) begin
        mem[mem_addr[31:2]] = mem_data_in;
        bcnt = busy_len;
      end else if (bcnt > 0) bcnt--;
      cwe_q = mem_is_write;
      mem_busy = busy_stuck || bcnt > 0;
      mem_data_out = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : {mem_addr[31:2], 2'b00} ^ 32'hDEADBEEF;
    end
  end

  function automatic vec_t mk(input logic dv, dwe, input logic [31:0] daddr, dwdata, input int blen,
                              input logic stuck, iv, input logic [31:0] iaddr, input int d_at, i_at,
                              input logic [31:0] d_rd, i_rd, maddr, input logic to);
    vec_t v;
    v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata; v.blen = blen; v.stuck = stuck;
    v.iv = iv; v.iaddr = iaddr; v.d_at = d_at; v.i_at = i_at; v.d_rd = d_rd; v.i_rd = i_rd;
    v.maddr = maddr; v.to = to;
    return v;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return shadow.exists(a[31:2]) ? shadow[a[31:2]] : {a[31:2], 2'b00} ^ 32'hDEADBEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50M);
    #1;
    if (mem_is_write && !prev_we) begin
      if (seen_pulse) chk("we_low_gap_ge2", 32'(low_run >= 2), 32'd1);
      seen_pulse = 1;
    end
    low_run = mem_is_write ? 0 : low_run + 1;
    prev_we = mem_is_write;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic run(input vec_t v, input string nm);
    int d_at = 0, i_at = 0, we_len = 0, lw_len = 0;
    logic [31:0] d_rd = 0, i_rd = 0;
    d_req = v.dv; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    i_req = v.iv; i_addr = v.iaddr; busy_len = v.blen; busy_stuck = v.stuck;
    for (int c = 1; c <= 60 && (d_req || i_req); c++) begin
      tick();
      we_len += int'(mem_is_write);
      lw_len += int'(mem_opt_is_lw);
      if (d_ack && d_at == 0) begin d_at = c; d_rd = d_rdata; d_req = 0; end
      if (i_ack && i_at == 0) begin i_at = c; i_rd = i_rdata; i_req = 0; end
    end
    d_req = 0; i_req = 0; busy_stuck = 0;
    if (v.dv && v.dwe) shadow[v.daddr[31:2]] = v.dwdata;
    tick();
    chk({nm, " d_ack_cycle"}, 32'(d_at), 32'(v.d_at));
    chk({nm, " i_ack_cycle"}, 32'(i_at), 32'(v.i_at));
    if (v.dv && !v.dwe) chk({nm, " d_rdata"}, d_rd, v.d_rd);
    if (v.iv) chk({nm, " i_rdata"}, i_rd, v.i_rd);
    chk({nm, " mem_addr"}, mem_addr, v.maddr);
    chk({nm, " wr_timeout"}, 32'(wr_timeout), 32'(v.to));
    chk({nm, " we_cycles"}, 32'(we_len), 32'((v.dv && v.dwe) ? WP : 0));
    chk({nm, " lw_cycles"}, 32'(lw_len), 32'((int'(v.dv && !v.dwe) + int'(v.iv)) * RW));
  endtask

  initial begin
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 32'h10000004, 0, 3, 0, 32'h3C1D8000, 32'h10000004, 0);
    tbl[1] = mk(1, 1, 32'h1FD003F8, 32'h41, 4, 0, 0, 0, 6, 0, 0, 0, 32'h1FD003F8, 0);
    tbl[2] = mk(1, 0, 32'h1FD003F8, 0, 0, 0, 0, 0, 3, 0, 32'h41, 0, 32'h1FD003F8, 0);
    tbl[4] = mk(1, 1, 32'h103, 32'h12345678, 0, 0, 0, 0, 4, 0, 0, 0, 32'h100, 0);
    tbl[5] = mk(1, 1, 32'h104, 32'hA5A5A5A5, 1, 0, 0, 0, 4, 0, 0, 0, 32'h104, 0);
    tbl[7] = mk(1, 1, 32'h40, 32'hCAFE, 0, 1, 0, 0, WP + TO + 1, 0, 0, 0, 32'h40, 1);
`ifdef MEM_ARB_RR_EN
    tbl[3] = mk(1, 0, 32'h200, 0, 0, 0, 1, 32'h10000000, 7, 3, 32'hDEADBCEF, 32'hCEADBEEF, 32'h200, 0);
    tbl[6] = mk(1, 0, 32'h104, 0, 0, 0, 1, 32'h101, 7, 3, 32'hA5A5A5A5, 32'h12345678, 32'h104, 0);
`else
    tbl[3] = mk(1, 0, 32'h200, 0, 0, 0, 1, 32'h10000000, 3, 7, 32'hDEADBCEF, 32'hCEADBEEF, 32'h10000000, 0);
    tbl[6] = mk(1, 0, 32'h104, 0, 0, 0, 1, 32'h101, 3, 7, 32'hA5A5A5A5, 32'h12345678, 32'h100, 0);
`endif
    tick();
    do_reset();
    chk("rst_ctrl_bits", {27'b0, mem_is_write, mem_opt_is_lw, d_ack, i_ack, wr_timeout}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h77; busy_len = 0;
    tick();
    chk("midwr_pulse1", 32'(mem_is_write), 32'd1);
    tick();
    chk("midwr_pulse2", 32'(mem_is_write), 32'd1);
    rst = 1; d_req = 0;
    tick();
    rst = 0;
    chk("midwr_we_low", 32'(mem_is_write), 32'd0);
    chk("midwr_no_ack", 32'(d_ack), 32'd0);
    chk("midwr_addr_clr", mem_addr, 32'd0);
    begin
      logic late = 0;
      for (int k = 0; k < 4; k++) begin tick(); late |= d_ack | i_ack | mem_is_write | mem_opt_is_lw; end
      chk("midwr_stays_idle", 32'(late), 32'd0);
    end
    for (int r = 0; r < 8; r++) run(tbl[r], $sformatf("row%0d", r));
    run(mk(1, 0, 32'h40, 0, 0, 0, 0, 0, 3, 0, 32'hCAFE, 0, 32'h40, 1), "sticky_to");
    do_reset();
    chk("to_cleared_by_rst", 32'(wr_timeout), 32'd0);
    rr_i = 0;
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      logic fi, li;
      int e, ld;
      v.dv = 1'($urandom_range(0, 1));
      v.iv = v.dv ? 1'($urandom_range(0, 1)) : 1'b1;
      v.dwe = v.dv & 1'($urandom_range(0, 1));
      v.daddr = 32'h3000 + 32'($urandom_range(0, 31));
      v.iaddr = 32'h3000 + 32'($urandom_range(0, 31));
      v.dwdata = $urandom;
      v.blen = int'($urandom_range(0, 6));
      v.stuck = 0; v.to = 0;
      e = (WP + 1 > v.blen + 1) ? WP + 1 : v.blen + 1;
      if (e > WP + TO) e = WP + TO;
      ld = v.dwe ? e + 1 : RW + 1;
      fi = v.iv && (!v.dv || rr_i);
      v.d_at = !v.dv ? 0 : (fi ? RW + 2 + ld : ld);
      v.i_at = !v.iv ? 0 : (fi ? RW + 1 : ld + RW + 2);
      v.d_rd = rd(v.daddr);
      v.i_rd = (v.dwe && !fi && v.daddr[31:2] == v.iaddr[31:2]) ? v.dwdata : rd(v.iaddr);
      li = (v.dv && v.iv) ? !fi : v.iv;
      v.maddr = {(li ? v.iaddr[31:2] : v.daddr[31:2]), 2'b00};
`ifdef MEM_ARB_RR_EN
      rr_i = !li;
`endif
      run(v, $sformatf("rand%0d", n));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory controller between two CPU requesters: port D (data/MEM stage) and port I (instruction fetch).
- Serialises accesses into the controller's is_write/addr/data_in/busy interface.
- Produces the rising is_write edge the controller needs, waits out write and recovery time, and returns read data with a one-cycle ack.
- Sits between the pipeline and the physical memory controller. All registers update on the rising edge of clk50M, so their outputs are stable at the controller's falling-edge sampling.

Parameters:
- READ_WAIT, 2, cycles the address is held before read data is captured (1..15).
- WR_PULSE, 2, cycles mem_is_write is held high (≥1; guarantees one controller sample edge).
- WR_TIMEOUT, 15, maximum WR_WAIT cycles before a forced completion (1..15).

Ports:
- clk50M  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d_req  in  1  data port request; hold until d_ack
- d_we  in  1  data port write (1) / read (0)
- d_addr  in  32  data port byte address
- d_wdata  in  32  data port write data
- d_rdata  out  32  data port read data, valid in d_ack cycle
- d_ack  out  1  one-cycle completion pulse
- i_req  in  1  fetch request (read only)
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch data, valid in i_ack cycle
- i_ack  out  1  one-cycle completion pulse
- mem_is_write  out  1  to controller is_write
- mem_opt_is_lw  out  1  to controller opt_is_lw; high in RD state only
- mem_addr  out  32  to controller addr, with bits [1:0] forced to 0
- mem_data_in  out  32  to controller data_in
- mem_data_out  in  32  from controller data_out
- mem_busy  in  1  from controller busy
- wr_timeout  out  1  sticky flag: a write was force-completed

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state returns to IDLE from any state, including mid-transaction.
  - mem_is_write, mem_opt_is_lw, d_ack, i_ack and wr_timeout go to 0.
  - d_rdata, i_rdata, mem_addr and mem_data_in go to 0.
  - The RR priority pointer goes to D.
  - No ack is produced for an in-flight request; requesters re-present it after reset.
- Request/ack handshake:
  - A requester keeps req, addr, we and wdata stable until its ack.
  - The arbiter latches the request fields at grant and ignores later changes.
  - An ack lasts exactly one cycle; rdata holds its value until the next ack on that port.
- IDLE:
  - Default policy is fixed priority, D over I.
  - On grant, latch the port id, addr, we and wdata, and clear the counter.
  - Go to WR_PULSE if the granted request is a write, otherwise RD.
  - With no request, outputs stay idle: mem_is_write=0, mem_opt_is_lw=0, mem_addr keeps its last value.
- RD:
  - Drive mem_addr and mem_opt_is_lw=1; the counter increments each cycle.
  - When the counter reaches READ_WAIT-1, capture mem_data_out into the granted port's rdata and go to RESP.
  - Read latency from grant to ack is READ_WAIT+1 cycles.
- WR_PULSE: hold mem_is_write=1 with mem_addr and mem_data_in stable for WR_PULSE cycles, then go to WR_WAIT with the counter cleared.
- WR_WAIT:
  - mem_is_write=0.
  - Go to RESP on the first cycle with mem_busy=0 (the controller has returned to READ).
  - If the counter reaches WR_TIMEOUT first, set wr_timeout and go to RESP anyway.
- RESP:
  - Pulse the granted port's ack and go to IDLE.
  - This guarantees mem_is_write is low for at least 2 cycles between writes, so the controller always sees a fresh rising edge.
- Back-to-back requests:
  - Each transaction is followed by at least one IDLE cycle.
  - A requester that drops req in its ack cycle and re-raises it is re-arbitrated normally.
- Simultaneous requests: d_req and i_req high in the same IDLE cycle grant D (fixed priority); I waits.
- Request dropped without ack: this is a protocol violation. The arbiter completes the latched transaction and still pulses the ack.
- Width rules:
  - The counter is 4 bits.
  - Writes forward the full 32-bit word; byte lanes are the controller's concern.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer gives priority to the port not granted last.
  - On simultaneous requests the pointer's port wins; the pointer updates at each grant.
  - With a single requester that requester is granted regardless of the pointer.
- Undefined: fixed D-over-I priority; the pointer logic is not built.

Test Plan:
- Reset mid-write: d_req, d_we=1, d_addr=0x00000100; assert rst in the 2nd WR_PULSE cycle -> next cycle mem_is_write=0, state IDLE, no d_ack.
- Single fetch: i_req with i_addr=0x10000004, mem_data_out model returns 0x3C1D8000; READ_WAIT=2 -> mem_opt_is_lw=1 for 2 cycles, i_ack 3 cycles after grant, i_rdata=0x3C1D8000, mem_addr=0x10000004.
- Data write: d_addr=0x1FD003F8, d_wdata=0x41; controller model holds busy for 4 cycles -> mem_is_write high exactly 2 cycles, d_ack one cycle after busy falls, wr_timeout=0.
- Contention: d_req (read 0x200) and i_req (read 0x10000000) in the same cycle -> D served first, then I. With MEM_ARB_RR_EN defined and the previous grant D, I is served first.
- Write timeout: mem_busy stuck at 1 after the write -> d_ack after WR_PULSE+WR_TIMEOUT+1 cycles, wr_timeout=1 and stays 1 until rst.
- Unaligned address and back-to-back writes: d_addr=0x00000103 -> mem_addr=0x00000100. Two consecutive writes -> mem_is_write low for at least 2 cycles between the two pulses.
